// File: rtl/memory_access_sequencer.sv
// rtl/memory_access_sequencer.sv - per-instruction control FSM ahead of the memory controller
// Optional macro: MEMORY_ACCESS_SEQUENCER_PERF_COUNTERS_EN adds retiredCount/memoryCycles outputs.
module memory_access_sequencer #(
  parameter int unsigned FETCH_LATENCY      = 1,
  parameter bit          HALT_ON_BAD_OPCODE = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        stall,
  input  logic        memoryUnalignedAccess,
  input  logic        memoryBadFunct3,
  output logic [1:0]  memoryMode,
  output logic [2:0]  funct3,
  output logic        rdWriteEnable,
  output logic        pcAdvance,
  output logic        halted,
  output logic [1:0]  haltCause
`ifdef MEMORY_ACCESS_SEQUENCER_PERF_COUNTERS_EN
  ,
  output logic [63:0] retiredCount,
  output logic [31:0] memoryCycles
`endif
);

  // Memory controller mode encoding
  localparam logic [1:0] MODE_NOP           = 2'd0;
  localparam logic [1:0] MODE_LOAD          = 2'd1;
  localparam logic [1:0] MODE_STORE_PRELOAD = 2'd2;
  localparam logic [1:0] MODE_STORE         = 2'd3;

  // Halt cause encoding
  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_UNALIGNED = 2'b01;
  localparam logic [1:0] CAUSE_FUNCT3    = 2'b10;
  localparam logic [1:0] CAUSE_OPCODE    = 2'b11;

  // RV32 major opcodes
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] LATENCY = 3'(FETCH_LATENCY);

  typedef enum logic [2:0] {
    ST_INIT         = 3'd0,
    ST_FETCH_WAIT   = 3'd1,
    ST_EXECUTE      = 3'd2,
    ST_LOAD_WB      = 3'd3,
    ST_STORE_COMMIT = 3'd4,
    ST_HALTED       = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;
  logic [6:0] opcode;
  logic       any_flag;
  logic       unused_instr_bits;

  assign opcode            = instruction[6:0];
  assign funct3            = instruction[14:12];
  assign haltCause         = cause_q;
  assign any_flag          = memoryUnalignedAccess | memoryBadFunct3;
  assign unused_instr_bits = ^{instruction[31:15], instruction[11:7]};

  // State, fetch-wait counter and captured halt cause
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= LATENCY;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and outputs; flags only steer the transition, never memoryMode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cause_d       = cause_q;
    memoryMode    = MODE_NOP;
    rdWriteEnable = 1'b0;
    pcAdvance     = 1'b0;
    halted        = 1'b0;

    case (state_q)
      ST_INIT, ST_FETCH_WAIT: begin
        // stall only freezes the post-retire wait, not the reset wait
        if (state_q == ST_INIT || !stall) begin
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = ST_EXECUTE;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end

      ST_EXECUTE: begin
        if (!stall) begin
          case (opcode)
            OPC_LOAD: begin
              memoryMode = MODE_LOAD;
              if (any_flag) begin
                state_d = ST_HALTED;
                cause_d = memoryBadFunct3 ? CAUSE_FUNCT3 : CAUSE_UNALIGNED;
              end else begin
                state_d = ST_LOAD_WB;
              end
            end
            OPC_STORE: begin
              // Always preload first so a faulting store never writes
              memoryMode = MODE_STORE_PRELOAD;
              if (any_flag) begin
                state_d = ST_HALTED;
                cause_d = memoryBadFunct3 ? CAUSE_FUNCT3 : CAUSE_UNALIGNED;
              end else begin
                state_d = ST_STORE_COMMIT;
              end
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_OP_IMM, OPC_OP: begin
              rdWriteEnable = 1'b1;
              pcAdvance     = 1'b1;
              state_d       = ST_FETCH_WAIT;
            end
            OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM: begin
              pcAdvance = 1'b1;
              state_d   = ST_FETCH_WAIT;
            end
            default: begin
              if (HALT_ON_BAD_OPCODE) begin
                state_d = ST_HALTED;
                cause_d = CAUSE_OPCODE;
              end else begin
                pcAdvance = 1'b1;
                state_d   = ST_FETCH_WAIT;
              end
            end
          endcase
        end
      end

      ST_LOAD_WB: begin
        // Address held so the synchronous read data stays valid for writeback
        memoryMode    = MODE_LOAD;
        rdWriteEnable = 1'b1;
        pcAdvance     = 1'b1;
        state_d       = ST_FETCH_WAIT;
      end

      ST_STORE_COMMIT: begin
        memoryMode = MODE_STORE;
        pcAdvance  = 1'b1;
        state_d    = ST_FETCH_WAIT;
      end

      ST_HALTED: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase

    if (pcAdvance) begin
      cnt_d = LATENCY;
    end
  end

`ifdef MEMORY_ACCESS_SEQUENCER_PERF_COUNTERS_EN
  logic [63:0] retired_q;
  logic [31:0] memcyc_q;

  assign retiredCount = retired_q;
  assign memoryCycles = memcyc_q;

  // Retirement and memory-busy counters, frozen once halted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_q <= 64'd0;
      memcyc_q  <= 32'd0;
    end else if (!halted) begin
      if (pcAdvance) begin
        retired_q <= retired_q + 64'd1;
      end
      if (memoryMode != MODE_NOP) begin
        memcyc_q <= memcyc_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_memory_access_sequencer.sv
// tb/tb_memory_access_sequencer.sv - table-driven scoreboard bench for memory_access_sequencer
module tb_memory_access_sequencer;

  localparam logic [1:0] NOP = 2'd0;
  localparam logic [1:0] LD  = 2'd1;
  localparam logic [1:0] SP  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  localparam logic [31:0] ADDI = 32'h00000013;
  localparam logic [31:0] LW   = 32'h0000A083;
  localparam logic [31:0] SB   = 32'h00208023;
  localparam logic [31:0] SW   = 32'h00202123;
  localparam logic [31:0] BAD  = 32'h0000007F;
  localparam logic [31:0] BAD2 = 32'h00000010;
  localparam logic [31:0] BEQ  = 32'h00000063;

  typedef struct {
    logic        rst;
    logic [31:0] ins;
    logic        st;
    logic        ua;
    logic        bf;
    logic [1:0]  mode;
    logic        rdwe;
    logic        pc;
    logic        hlt;
    logic [1:0]  cause;
  } vec_t;

  typedef struct {
    int          idx;
    logic [1:0]  mode;
    logic [2:0]  f3;
    logic        rdwe;
    logic        pc;
    logic        hlt;
    logic [1:0]  cause;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'd0;
  logic        stall = 1'b0;
  logic        ua = 1'b0;
  logic        bf = 1'b0;
  logic [1:0]  memoryMode;
  logic [2:0]  funct3;
  logic        rdWriteEnable;
  logic        pcAdvance;
  logic        halted;
  logic [1:0]  haltCause;

  logic        rst0 = 1'b1;
  logic [31:0] ins0 = 32'h0000007F;
  logic [1:0]  mode0;
  logic [2:0]  f30;
  logic        rdwe0;
  logic        pc0;
  logic        hlt0;
  logic [1:0]  cause0;

  int passed = 0;
  int total  = 0;

  vec_t vecs[$];
  exp_t sbq[$];

  always #5 clock = ~clock;

  memory_access_sequencer #(.FETCH_LATENCY(1), .HALT_ON_BAD_OPCODE(1'b1)) dut (
    .clock(clock), .reset(reset), .instruction(instruction), .stall(stall),
    .memoryUnalignedAccess(ua), .memoryBadFunct3(bf),
    .memoryMode(memoryMode), .funct3(funct3), .rdWriteEnable(rdWriteEnable),
    .pcAdvance(pcAdvance), .halted(halted), .haltCause(haltCause)
  );

  memory_access_sequencer #(.FETCH_LATENCY(2), .HALT_ON_BAD_OPCODE(1'b0)) dut0 (
    .clock(clock), .reset(rst0), .instruction(ins0), .stall(1'b0),
    .memoryUnalignedAccess(1'b0), .memoryBadFunct3(1'b0),
    .memoryMode(mode0), .funct3(f30), .rdWriteEnable(rdwe0),
    .pcAdvance(pc0), .halted(hlt0), .haltCause(cause0)
  );

  task automatic v(input logic rst, input logic [31:0] ins, input logic st, input logic fu,
                   input logic fb, input logic [1:0] mode, input logic rdwe, input logic pc,
                   input logic hlt, input logic [1:0] cause);
    vec_t r;
    r.rst = rst; r.ins = ins; r.st = st; r.ua = fu; r.bf = fb;
    r.mode = mode; r.rdwe = rdwe; r.pc = pc; r.hlt = hlt; r.cause = cause;
    vecs.push_back(r);
  endtask

  initial begin
    exp_t  e;
    vec_t  r;
    logic [5:0] pat;

    // addi after reset, FETCH_LATENCY=1: retire every 2 cycles
    v(1, ADDI, 0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, ADDI, 0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, ADDI, 0, 0, 0, NOP, 1, 1, 0, 2'b00);
    v(0, ADDI, 0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, ADDI, 0, 0, 0, NOP, 1, 1, 0, 2'b00);
    // lw
    v(0, LW,   0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, LW,   0, 0, 0, LD,  0, 0, 0, 2'b00);
    v(0, LW,   0, 0, 0, LD,  1, 1, 0, 2'b00);
    // sb
    v(0, SB,   0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, SB,   0, 0, 0, SP,  0, 0, 0, 2'b00);
    v(0, SB,   0, 0, 0, ST,  0, 1, 0, 2'b00);
    // stalled lw, stall ignored in LOAD_WB, honoured in FETCH_WAIT
    v(0, LW,   0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, LW,   1, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, LW,   1, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, LW,   1, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, LW,   0, 0, 0, LD,  0, 0, 0, 2'b00);
    v(0, LW,   1, 0, 0, LD,  1, 1, 0, 2'b00);
    v(0, ADDI, 1, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, ADDI, 0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, ADDI, 0, 0, 0, NOP, 1, 1, 0, 2'b00);
    // flags ignored while memoryMode is NOP
    v(0, ADDI, 0, 1, 1, NOP, 0, 0, 0, 2'b00);
    v(0, ADDI, 0, 1, 1, NOP, 1, 1, 0, 2'b00);
    v(0, SW,   0, 0, 0, NOP, 0, 0, 0, 2'b00);
    // sw unaligned: never STORE, halt cause 01 held 10 cycles
    v(0, SW,   0, 1, 0, SP,  0, 0, 0, 2'b00);
    for (int k = 0; k < 10; k++) v(0, SW, 0, 0, 0, NOP, 0, 0, 1, 2'b01);
    // both flags during load -> 10
    v(1, LW,   0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, LW,   0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, LW,   0, 1, 1, LD,  0, 0, 0, 2'b00);
    v(0, LW,   0, 0, 0, NOP, 0, 0, 1, 2'b10);
    v(0, ADDI, 0, 1, 0, NOP, 0, 0, 1, 2'b10);
    // bad opcodes -> 11
    v(1, BAD,  0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, BAD,  0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, BAD,  0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, BAD,  0, 0, 0, NOP, 0, 0, 1, 2'b11);
    v(1, BAD2, 0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, BAD2, 0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, BAD2, 0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, BAD2, 0, 0, 0, NOP, 0, 0, 1, 2'b11);
    // reset during STORE_PRELOAD: no STORE afterwards
    v(1, SB,   0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, SB,   0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, SB,   0, 0, 0, SP,  0, 0, 0, 2'b00);
    v(1, SB,   0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, ADDI, 0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, ADDI, 0, 0, 0, NOP, 1, 1, 0, 2'b00);
    // branch, then flag in LOAD_WB ignored
    v(0, BEQ,  0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, BEQ,  0, 0, 0, NOP, 0, 1, 0, 2'b00);
    v(0, LW,   0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, LW,   0, 0, 0, LD,  0, 0, 0, 2'b00);
    v(0, LW,   0, 0, 1, LD,  1, 1, 0, 2'b00);
    v(0, ADDI, 0, 0, 0, NOP, 0, 0, 0, 2'b00);
    v(0, ADDI, 0, 0, 0, NOP, 1, 1, 0, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clock);
      #1;
      r = vecs[i];
      reset = r.rst; instruction = r.ins; stall = r.st; ua = r.ua; bf = r.bf;
      e.idx = i; e.mode = r.mode; e.f3 = r.ins[14:12]; e.rdwe = r.rdwe;
      e.pc = r.pc; e.hlt = r.hlt; e.cause = r.cause;
      sbq.push_back(e);
      @(negedge clock);
      e = sbq.pop_front();
      total++;
      if (memoryMode === e.mode && funct3 === e.f3 && rdWriteEnable === e.rdwe &&
          pcAdvance === e.pc && halted === e.hlt && haltCause === e.cause) begin
        passed++;
      end else begin
        $display("FAIL vec%0d: got mode=%0d f3=%0d rdwe=%0d pc=%0d halted=%0d cause=%0d, want mode=%0d f3=%0d rdwe=%0d pc=%0d halted=%0d cause=%0d",
                 e.idx, memoryMode, funct3, rdWriteEnable, pcAdvance, halted, haltCause,
                 e.mode, e.f3, e.rdwe, e.pc, e.hlt, e.cause);
      end
    end

    // Bad opcode retires as NOP when halting is disabled (FETCH_LATENCY=2)
    pat = 6'b100100;
    @(posedge clock);
    #1;
    rst0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      total++;
      if (pc0 === pat[k] && hlt0 === 1'b0 && rdwe0 === 1'b0 && mode0 === NOP) begin
        passed++;
      end else begin
        $display("FAIL nohalt_cyc%0d: got pc=%0d halted=%0d rdwe=%0d mode=%0d, want pc=%0d halted=0 rdwe=0 mode=0",
                 k, pc0, hlt0, rdwe0, mode0, pat[k]);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
